// File: rtl/matrix_mult_seq_ctrl_if.sv
// Host-side stream interface of the matrix-multiply sequencer: command, A/B input stream,
// C output stream and status.
interface matrix_mult_seq_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [31:0]           size_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, size_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done, err
  );

  modport slave (
    input  start, size_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, err
  );
endinterface

// File: rtl/matrix_mult_seq_ctrl.sv
// Sequencer for the flat parallel matrix-multiply core: streams A and B into flat registers,
// waits for the core to settle, then streams C back out row-major.
module matrix_mult_seq_ctrl #(
  parameter int unsigned MAX_SIZE      = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  matrix_mult_seq_ctrl_if.slave                    bus,
  output logic [31:0]                              core_size,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  core_A,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  core_B,
  input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  core_C
);
  localparam int unsigned FLAT_W = MAX_SIZE * MAX_SIZE * DATA_WIDTH;
  localparam int unsigned CW     = $clog2(MAX_SIZE + 1);
  localparam int unsigned IW     = $clog2(MAX_SIZE * MAX_SIZE + 1);
  localparam int unsigned BW     = $clog2(FLAT_W);
  localparam int unsigned SW     = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, SETTLE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         r_q, r_d, c_q, c_d;
  logic [SW-1:0]         set_cnt_q, set_cnt_d;
  logic [31:0]           core_size_q, core_size_d;
  logic [FLAT_W-1:0]     core_a_q, core_a_d, core_b_q, core_b_d, creg_q, creg_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [CW-1:0] n_last, nxt_r, nxt_c;
  logic          row_last, col_last, size_ok, in_hs;
  logic [IW-1:0] cur_idx, nxt_idx;
  logic [BW-1:0] cur_base, nxt_base;

  // Counter bookkeeping shared by the load and drain phases
  always_comb begin
    n_last   = CW'(core_size_q - 32'd1);
    row_last = (r_q == n_last);
    col_last = (c_q == n_last);
    nxt_c    = col_last ? '0 : c_q + CW'(1);
    nxt_r    = col_last ? r_q + CW'(1) : r_q;
    cur_idx  = IW'(r_q) * IW'(MAX_SIZE) + IW'(c_q);
    nxt_idx  = IW'(nxt_r) * IW'(MAX_SIZE) + IW'(nxt_c);
    cur_base = BW'(cur_idx) * BW'(DATA_WIDTH);
    nxt_base = BW'(nxt_idx) * BW'(DATA_WIDTH);
    size_ok  = (bus.size_in >= 32'd1) && (bus.size_in <= 32'(MAX_SIZE));
    in_hs    = bus.in_valid && in_ready_q;
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    set_cnt_d   = set_cnt_q;
    core_size_d = core_size_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    creg_d      = creg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (size_ok) begin
            state_d     = LOAD_A;
            core_size_d = bus.size_in;
            core_a_d    = '0;
            core_b_d    = '0;
            r_d         = '0;
            c_d         = '0;
            busy_d      = 1'b1;
            in_ready_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (in_hs) begin
          if (state_q == LOAD_A) core_a_d[cur_base +: DATA_WIDTH] = bus.in_data;
          else                   core_b_d[cur_base +: DATA_WIDTH] = bus.in_data;
          if (row_last && col_last) begin
            r_d = '0;
            c_d = '0;
            if (state_q == LOAD_A) begin
              state_d = LOAD_B;
            end else begin
              state_d    = SETTLE;
              set_cnt_d  = '0;
              in_ready_d = 1'b0;
            end
          end else begin
            r_d = nxt_r;
            c_d = nxt_c;
          end
        end
      end
      SETTLE: begin
        // Element 0 comes straight from core_C since creg is loaded on this same edge
        if (set_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d     = DRAIN;
          creg_d      = core_C;
          out_valid_d = 1'b1;
          out_data_d  = core_C[DATA_WIDTH-1:0];
          out_last_d  = (n_last == '0);
        end else begin
          set_cnt_d = set_cnt_q + SW'(1);
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_last && col_last) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            r_d         = '0;
            c_d         = '0;
          end else begin
            r_d        = nxt_r;
            c_d        = nxt_c;
            out_data_d = creg_q[nxt_base +: DATA_WIDTH];
            out_last_d = (nxt_r == n_last) && (nxt_c == n_last);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      set_cnt_q   <= '0;
      core_size_q <= '0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      creg_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      set_cnt_q   <= set_cnt_d;
      core_size_q <= core_size_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      creg_q      <= creg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign core_size     = core_size_q;
  assign core_A        = core_a_q;
  assign core_B        = core_b_q;
endmodule

// File: tb/tb_matrix_mult_seq_ctrl.sv
// Scoreboard bench for matrix_mult_seq_ctrl with a behavioural model of the flat multiply core.
module tb_matrix_mult_seq_ctrl;
  localparam int unsigned MAX = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned SC  = 4;
  localparam int unsigned FW  = MAX * MAX * DW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   core_size;
  logic [FW-1:0] core_A, core_B, core_C;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ph       = 0;
  bit   bp_en    = 1'b0;
  bit   done_exp = 1'b0;

  matrix_mult_seq_ctrl_if #(.DATA_WIDTH(DW)) bus();

  matrix_mult_seq_ctrl #(
    .MAX_SIZE(MAX), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .core_size(core_size), .core_A(core_A), .core_B(core_B), .core_C(core_C)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the combinational core: full MAX x MAX product modulo 2^DW
  function automatic logic [FW-1:0] core_model(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW-1:0] c;
    logic [DW-1:0] s;
    c = '0;
    for (int i = 0; i < int'(MAX); i++) begin
      for (int j = 0; j < int'(MAX); j++) begin
        s = '0;
        for (int k = 0; k < int'(MAX); k++)
          s = s + a[(i*MAX+k)*DW +: DW] * b[(k*MAX+j)*DW +: DW];
        c[(i*MAX+j)*DW +: DW] = s;
      end
    end
    return c;
  endfunction

  assign core_C = core_model(core_A, core_B);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every presented element must match the queue head; pop on handshake
  always @(negedge clk) begin
    chk("done_pulse", 64'(bus.done), 64'(done_exp));
    done_exp = 1'b0;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_output");
      end else begin
        chk("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
        chk("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
        if (bus.out_ready) begin
          if (exp_q[0].last) done_exp = 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) begin
      bus.out_ready = (ph == 0);
      ph = (ph + 1) % 3;
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int n);
    bus.start   = 1'b1;
    bus.size_in = 32'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    logic acc;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 50; t++) begin
      acc = bus.in_ready;
      tick();
      if (acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    fail("send_timeout");
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.done) begin
      if (k >= 2000) begin
        fail("done_timeout");
        return;
      end
      tick();
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int k;
    bus.start = 1'b0; bus.size_in = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_out_last", 64'(bus.out_last), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_err", 64'(bus.err), 0);
    chk("rst_core_size", 64'(core_size), 0);
    chk("rst_core_A", 64'(|core_A), 0);
    chk("rst_core_B", 64'(|core_B), 0);

    // Basic 2x2 at full throughput: [1 2;3 4]*[5 6;7 8] = [19 22;43 50]
    push_exp(19, 0); push_exp(22, 0); push_exp(43, 0); push_exp(50, 1);
    do_start(2);
    c0 = cyc;
    chk("start_busy", 64'(bus.busy), 1);
    chk("start_in_ready", 64'(bus.in_ready), 1);
    for (int i = 1; i <= 4; i++) send(DW'(i), 0);
    for (int i = 5; i <= 8; i++) send(DW'(i), 0);
    wait_done();
    chk("latency_2x2", 64'(cyc - c0), 64'(16));
    chk("done_busy", 64'(bus.busy), 0);
    chk("core_size_2", 64'(core_size), 2);
    tick();
    chk("queue_empty_basic", 64'(exp_q.size()), 0);

    // Invalid sizes 0 and 11
    do_start(0);
    chk("err_size0", 64'(bus.err), 1);
    chk("busy_size0", 64'(bus.busy), 0);
    chk("in_ready_size0", 64'(bus.in_ready), 0);
    chk("core_size_hold0", 64'(core_size), 2);
    tick();
    chk("err_one_cycle0", 64'(bus.err), 0);
    do_start(11);
    chk("err_size11", 64'(bus.err), 1);
    chk("busy_size11", 64'(bus.busy), 0);
    chk("core_size_hold11", 64'(core_size), 2);
    tick();
    chk("err_one_cycle11", 64'(bus.err), 0);

    // Backpressure n=3: I * [1..9] = [1..9], out_ready pattern 1,0,0 and random input gaps
    for (int i = 1; i <= 9; i++) push_exp(DW'(i), i == 9);
    do_start(3);
    ph = 0;
    bp_en = 1'b1;
    for (int i = 0; i < 9; i++) send((i / 3) == (i % 3) ? DW'(1) : DW'(0), int'($urandom_range(0, 2)));
    for (int i = 1; i <= 9; i++) send(DW'(i), int'($urandom_range(0, 2)));
    wait_done();
    bp_en = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("queue_empty_bp", 64'(exp_q.size()), 0);

    // Full size: 0x10000 * 0x10000 = 2^32 wraps to 0 in every term
    for (int i = 0; i < 100; i++) push_exp('0, i == 99);
    do_start(10);
    for (int i = 0; i < 200; i++) send(32'h0001_0000, 0);
    wait_done();
    tick();
    chk("queue_empty_full", 64'(exp_q.size()), 0);

    // Reset during LOAD_B discards everything
    do_start(3);
    for (int i = 0; i < 9; i++) send(DW'(i + 1), 0);
    for (int i = 0; i < 4; i++) send(DW'(i + 20), 0);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 64'(bus.busy), 0);
    chk("midrst_in_ready", 64'(bus.in_ready), 0);
    chk("midrst_core_A", 64'(|core_A), 0);
    chk("midrst_core_B", 64'(|core_B), 0);
    rst = 1'b0;
    tick();
    push_exp(42, 1);
    do_start(1);
    send(6, 0);
    send(7, 0);
    wait_done();
    tick();
    chk("queue_empty_n1", 64'(exp_q.size()), 0);

    // Settle timing and start ignored in DRAIN: [2 0;1 3]*[1 2;3 4] = [2 4;10 14]
    bus.out_ready = 1'b0;
    push_exp(2, 0); push_exp(4, 0); push_exp(10, 0); push_exp(14, 1);
    do_start(2);
    send(2, 0); send(0, 0); send(1, 0); send(3, 0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      chk("settle_busy", 64'(bus.busy), 1);
      chk("settle_in_ready", 64'(bus.in_ready), 0);
      tick();
      k++;
    end
    chk("settle_cycles", 64'(k), 64'(SC));
    do_start(3);
    chk("ignored_start_err", 64'(bus.err), 0);
    chk("ignored_start_busy", 64'(bus.busy), 1);
    chk("ignored_start_size", 64'(core_size), 2);
    chk("ignored_start_valid", 64'(bus.out_valid), 1);
    repeat (3) tick();
    bus.out_ready = 1'b1;
    wait_done();
    tick();
    chk("queue_empty_final", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
